alu_arbiter: RTL

//  Shares the single combinational ALU between two requesters (port 0: execute

---
 rtl/alu_arbiter.sv | 95 +++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// One operation in flight; the result is registered and returned on a per-requester response handshake.
module alu_arbiter #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [OP_W-1:0]   req_op0,
  input  logic [OP_W-1:0]   req_op1,
  input  logic [DATA_W-1:0] req_a0,
  input  logic [DATA_W-1:0] req_a1,
  input  logic [DATA_W-1:0] req_b0,
  input  logic [DATA_W-1:0] req_b1,
  output logic [1:0]        resp_valid,
  input  logic [1:0]        resp_ready,
  output logic [DATA_W-1:0] resp_result,
  output logic              resp_zero,
  output logic [OP_W-1:0]   alu_opcode,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  output logic              busy
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
  // req_ready is derived combinationally from req_valid; requesters hold valid and
  // payload until accepted. resp_valid/result stay stable until resp_ready[gnt].
  typedef enum logic {IDLE = 1'b0, RESP = 1'b1} state_t;

  state_t              state_q, state_d;
  logic                last_q, last_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic                zero_q, zero_d;
  logic                winner;
  logic                issue;
  logic                sel;

  always_comb begin
    winner = req_valid[1];
    if (req_valid == 2'b11) winner = ~last_q;
    issue  = (state_q == IDLE) && (|req_valid) && !reset;
    // Outside an issue cycle the ALU sees the last-granted requester's fields.
    sel    = issue ? winner : last_q;
  end

  assign alu_opcode  = sel ? req_op1 : req_op0;
  assign alu_a       = sel ? req_a1  : req_a0;
  assign alu_b       = sel ? req_b1  : req_b0;

  assign req_ready   = issue ? (winner ? 2'b10 : 2'b01) : 2'b00;
  assign resp_valid  = (state_q == RESP) ? (last_q ? 2'b10 : 2'b01) : 2'b00;
  assign busy        = (state_q == RESP);
  assign resp_result = result_q;
  assign resp_zero   = zero_q;

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    result_d = result_q;
    zero_d   = zero_q;
    case (state_q)
      IDLE: begin
        if (issue) begin
          state_d  = RESP;
          last_d   = winner;
          result_d = alu_result;
          zero_d   = alu_zero;
        end
      end
      RESP: begin
        if (resp_ready[last_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      last_q   <= 1'b1;
      result_q <= '0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

endmodule
